vin_pixel_packer: RTL and testbench

- Parametrised successor to the DVI input pixel path. Takes one RGB pixel per clock from the TMDS decoder, converts it to luma and packs PIX_PER_BEAT pixels into one output beat qualified by a valid strobe. The strobe replaces the old divided pixel clock.
- Adds:
  - skipping of the first frames after reset;
  - re-synchronisation on every DE rise;
  - zero-padded flush of partial beats at line end;
  - start-of-frame and end-of-line markers.
- Sits between the TMDS decoder and the frame-buffer writer.

---
 rtl/vin_pkg.sv | 27 ++
 rtl/vin_rgb2y.sv | 27 ++
 rtl/vin_pixel_packer.sv | 212 +++++++++++++++++++++
 tb/tb_vin_pixel_packer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vin_pkg.sv
// Shared definitions for the DVI input pixel path: packer FSM states, luma
// coefficients and the stage-1 sync bundle.
package vin_pkg;

   typedef enum logic [1:0] {
      ST_SKIP   = 2'd0,
      ST_BLANK  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_FLUSH  = 2'd3
   } vin_state_t;

   // BT.601-style weights scaled by 256; they sum to 256 so white maps to full scale.
   localparam int unsigned COEF_R     = 77;
   localparam int unsigned COEF_G     = 150;
   localparam int unsigned COEF_B     = 29;
   localparam int unsigned COEF_SHIFT = 8;

   localparam int unsigned SKIP_W = 4;
   localparam int unsigned MEAS_W = 16;

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } vin_ctl_t;

endpackage

// File: rtl/vin_rgb2y.sv
// Combinational RGB to luma; returns the OUT_W MSBs of the IN_W-bit luma.
module vin_rgb2y
   import vin_pkg::*;
#(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 8
) (
   input  logic [IN_W-1:0]  red,
   input  logic [IN_W-1:0]  green,
   input  logic [IN_W-1:0]  blue,
   output logic [OUT_W-1:0] luma_c
);

   localparam int unsigned SUM_W = IN_W + COEF_SHIFT;
   localparam int unsigned DROP  = COEF_SHIFT + IN_W - OUT_W;

   logic [SUM_W-1:0] sum_c;

   // Coefficients sum to 2^COEF_SHIFT, so SUM_W bits can never overflow.
   always_comb begin
      sum_c  = SUM_W'(COEF_R) * SUM_W'(red)
             + SUM_W'(COEF_G) * SUM_W'(green)
             + SUM_W'(COEF_B) * SUM_W'(blue);
      luma_c = OUT_W'(sum_c >> DROP);
   end

endmodule

// File: rtl/vin_pixel_packer.sv
// Packs PIX_PER_BEAT luma pixels per output beat with SOF/EOL markers and frame skipping.
// Optional macro VIN_MEASURE_EN adds active width/height measurement.
module vin_pixel_packer
   import vin_pkg::*;
#(
   parameter int unsigned IN_W         = 8,
   parameter int unsigned OUT_W        = 8,
   parameter int unsigned PIX_PER_BEAT = 2,
   parameter int unsigned SKIP_FRAMES  = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_de,
   input  logic                          in_hsync,
   input  logic                          in_vsync,
   input  logic [IN_W-1:0]               in_red,
   input  logic [IN_W-1:0]               in_green,
   input  logic [IN_W-1:0]               in_blue,
   output logic                          out_valid,
   output logic [PIX_PER_BEAT*OUT_W-1:0] out_data,
   output logic                          out_sof,
   output logic                          out_eol,
   output logic                          out_hsync,
   output logic                          out_vsync,
   output logic [MEAS_W-1:0]             out_width,
   output logic [MEAS_W-1:0]             out_height
);

   localparam int unsigned DATA_W = PIX_PER_BEAT * OUT_W;
   localparam int unsigned IDX_W  = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_BEAT - 1);

   vin_ctl_t           s1_ctl;
   logic               s1_de_d, s1_vsync_d;
   logic [IN_W-1:0]    s1_red, s1_green, s1_blue;
   logic [OUT_W-1:0]   luma_c;
   logic               de_rise_c, vs_rise_c;

   vin_state_t         state_q, state_n;
   logic [IDX_W-1:0]   idx_q, idx_n, slot_c;
   logic [SKIP_W-1:0]  skip_q, skip_n;
   logic               sof_pend_q, sof_pend_n;
   logic [DATA_W-1:0]  pack_q, pack_n;
   logic               store_c, emit_c, eol_c, sof_c;

   // Stage 1: input capture plus previous-cycle copies for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_ctl     <= '0;
         s1_de_d    <= 1'b0;
         s1_vsync_d <= 1'b0;
         s1_red     <= '0;
         s1_green   <= '0;
         s1_blue    <= '0;
      end else begin
         s1_ctl     <= '{de: in_de, hsync: in_hsync, vsync: in_vsync};
         s1_de_d    <= s1_ctl.de;
         s1_vsync_d <= s1_ctl.vsync;
         s1_red     <= in_red;
         s1_green   <= in_green;
         s1_blue    <= in_blue;
      end
   end

   assign de_rise_c = s1_ctl.de & ~s1_de_d;
   assign vs_rise_c = s1_ctl.vsync & ~s1_vsync_d;

   vin_rgb2y #(.IN_W(IN_W), .OUT_W(OUT_W)) u_rgb2y (
      .red    (s1_red),
      .green  (s1_green),
      .blue   (s1_blue),
      .luma_c (luma_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_SKIP;
         idx_q      <= '0;
         skip_q     <= SKIP_W'(SKIP_FRAMES);
         sof_pend_q <= 1'b0;
         pack_q     <= '0;
      end else begin
         state_q    <= state_n;
         idx_q      <= idx_n;
         skip_q     <= skip_n;
         sof_pend_q <= sof_pend_n;
         pack_q     <= pack_n;
      end
   end

   // in_de (one cycle ahead of stage 1) tells whether the line continues, so a
   // beat closed by the end of line carries EOL without losing latency.
   always_comb begin
      state_n    = state_q;
      idx_n      = idx_q;
      skip_n     = skip_q;
      sof_pend_n = sof_pend_q;
      pack_n     = pack_q;
      store_c    = 1'b0;
      slot_c     = '0;
      emit_c     = 1'b0;
      eol_c      = 1'b0;
      sof_c      = 1'b0;

      case (state_q)
         ST_SKIP: begin
            if (skip_q == '0) begin
               state_n = ST_BLANK;
            end else if (vs_rise_c) begin
               skip_n = skip_q - SKIP_W'(1);
               if (skip_q == SKIP_W'(1)) begin
                  state_n    = ST_BLANK;
                  sof_pend_n = 1'b1;
               end
            end
         end
         ST_BLANK: begin
            if (vs_rise_c) sof_pend_n = 1'b1;
            if (de_rise_c) begin
               store_c = 1'b1;
               state_n = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (vs_rise_c) sof_pend_n = 1'b1;
            if (s1_ctl.de) begin
               store_c = 1'b1;
               slot_c  = idx_q;
            end else begin
               state_n = ST_BLANK;
               idx_n   = '0;
            end
         end
         ST_FLUSH: begin
            state_n = ST_BLANK;
            idx_n   = '0;
         end
         default: state_n = ST_SKIP;
      endcase

      if (store_c) begin
         // Slot 0 starts a fresh beat, so unfilled slots of a partial beat read 0.
         if (slot_c == '0) pack_n = '0;
         for (int unsigned i = 0; i < PIX_PER_BEAT; i++) begin
            if (slot_c == IDX_W'(i)) pack_n[(PIX_PER_BEAT-1-i)*OUT_W +: OUT_W] = luma_c;
         end
         if (slot_c == LAST_IDX || !in_de) begin
            emit_c     = 1'b1;
            eol_c      = ~in_de;
            sof_c      = sof_pend_n;
            sof_pend_n = 1'b0;
            idx_n      = '0;
            if (slot_c != LAST_IDX) state_n = ST_FLUSH;
         end else begin
            idx_n = slot_c + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_hsync <= 1'b0;
         out_vsync <= 1'b0;
      end else begin
         out_valid <= emit_c;
         out_sof   <= sof_c;
         out_eol   <= eol_c;
         if (emit_c) out_data <= pack_n;
         out_hsync <= s1_ctl.hsync & (state_n != ST_SKIP);
         out_vsync <= s1_ctl.vsync & (state_n != ST_SKIP);
      end
   end

`ifdef VIN_MEASURE_EN
   logic [MEAS_W-1:0] pix_cnt_q, line_cnt_q, line_inc_c;
   logic              de_fall_c;

   assign de_fall_c  = ~s1_ctl.de & s1_de_d;
   assign line_inc_c = (de_fall_c && line_cnt_q != '1) ? line_cnt_q + MEAS_W'(1) : line_cnt_q;

   // Saturating counters; a line ending on the vsync rise still counts toward that frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_cnt_q  <= '0;
         line_cnt_q <= '0;
         out_width  <= '0;
         out_height <= '0;
      end else begin
         if (de_fall_c) begin
            out_width <= pix_cnt_q;
            pix_cnt_q <= '0;
         end else if (s1_ctl.de && pix_cnt_q != '1) begin
            pix_cnt_q <= pix_cnt_q + MEAS_W'(1);
         end
         if (vs_rise_c) begin
            out_height <= line_inc_c;
            line_cnt_q <= '0;
         end else begin
            line_cnt_q <= line_inc_c;
         end
      end
   end
`else
   assign out_width  = '0;
   assign out_height = '0;
`endif

endmodule

// File: tb/tb_vin_pixel_packer.sv
// Self-checking bench: two packers (2 pixels/beat skipping 3 frames, 4 pixels/beat
// skipping none) fed the same stream and checked against a line-level beat model.
`timescale 1ns/1ps
module tb_vin_pixel_packer;

   localparam int unsigned IN_W  = 8;
   localparam int unsigned OUT_W = 8;
`ifdef VIN_MEASURE_EN
   localparam bit MEAS = 1'b1;
`else
   localparam bit MEAS = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        sof;
      logic        eol;
      logic [31:0] cyc;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic de = 1'b0, hs = 1'b0, vs = 1'b0;
   logic [IN_W-1:0] r = '0, g = '0, b = '0;
   logic [31:0] cyc = '0;

   logic        va, sofa, eola, hsa, vsa;
   logic [15:0] da, wa, ha;
   logic        vb, sofb, eolb, hsb, vsb;
   logic [31:0] db;
   logic [15:0] wb, hb;

   int n_tests = 0;
   int n_fail  = 0;

   beat_t got[2][$];
   beat_t expq[2][$];
   int    skip_left[2];
   bit    sof_pend[2];
   int    ppb[2] = '{2, 4};
   int    pr[$], pg[$], pb[$];

   vin_pixel_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .PIX_PER_BEAT(2), .SKIP_FRAMES(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_de(de), .in_hsync(hs), .in_vsync(vs),
      .in_red(r), .in_green(g), .in_blue(b),
      .out_valid(va), .out_data(da), .out_sof(sofa), .out_eol(eola),
      .out_hsync(hsa), .out_vsync(vsa), .out_width(wa), .out_height(ha)
   );

   vin_pixel_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .PIX_PER_BEAT(4), .SKIP_FRAMES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_de(de), .in_hsync(hs), .in_vsync(vs),
      .in_red(r), .in_green(g), .in_blue(b),
      .out_valid(vb), .out_data(db), .out_sof(sofb), .out_eol(eolb),
      .out_hsync(hsb), .out_vsync(vsb), .out_width(wb), .out_height(hb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   always @(negedge clk) begin
      if (va) got[0].push_back('{data: 32'(da), sof: sofa, eol: eola, cyc: cyc});
      if (vb) got[1].push_back('{data: db, sof: sofb, eol: eolb, cyc: cyc});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      skip_left[0] = 3;
      skip_left[1] = 0;
      sof_pend[0] = 1'b0;
      sof_pend[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         got[d].delete();
         expq[d].delete();
      end
   endtask

   task automatic add_px(input int rr, input int gg, input int bb);
      pr.push_back(rr);
      pg.push_back(gg);
      pb.push_back(bb);
   endtask

   task automatic add_rand_px(input int n);
      for (int i = 0; i < n; i++)
         add_px(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
   endtask

   // Vsync pulse: consumes a skip frame or arms SOF; out_vsync shows 2 cycles later unless skipping.
   task automatic send_vsync();
      logic exp_vs;
      for (int d = 0; d < 2; d++) begin
         if (skip_left[d] > 0) begin
            skip_left[d]--;
            if (skip_left[d] == 0) sof_pend[d] = 1'b1;
         end else begin
            sof_pend[d] = 1'b1;
         end
      end
      exp_vs = (skip_left[0] == 0);
      de = 1'b0;
      vs = 1'b1;
      step();
      step();
      n_tests++;
      if (vsa !== exp_vs || vsb !== 1'b1) begin
         n_fail++;
         $display("FAIL out_vsync: got a=%b b=%b expected a=%b b=1", vsa, vsb, exp_vs);
      end
      step();
      vs = 1'b0;
      step();
      step();
   endtask

   // Drives the queued pixels as one DE line, then hsync and a gap; models the resulting beats.
   task automatic send_line(input int gap);
      int    n;
      int    cy[$];
      int    y[$];
      int    last;
      beat_t e;
      n = pr.size();
      for (int i = 0; i < n; i++) begin
         de = 1'b1;
         r  = IN_W'(pr[i]);
         g  = IN_W'(pg[i]);
         b  = IN_W'(pb[i]);
         cy.push_back(int'(cyc));
         y.push_back(((77 * pr[i] + 150 * pg[i] + 29 * pb[i]) / 256) >> (IN_W - OUT_W));
         step();
      end
      de = 1'b0;
      hs = 1'b1;
      step();
      step();
      n_tests++;
      if (hsa !== (skip_left[0] == 0) || hsb !== 1'b1) begin
         n_fail++;
         $display("FAIL out_hsync: got a=%b b=%b expected a=%b b=1", hsa, hsb, skip_left[0] == 0);
      end
      hs = 1'b0;
      repeat (gap) step();
      for (int d = 0; d < 2; d++) begin
         if (skip_left[d] != 0) continue;
         for (int j = 0; j < n; j += ppb[d]) begin
            e.data = '0;
            for (int k = 0; k < ppb[d]; k++)
               e.data = (e.data << 8) | ((j + k < n) ? 32'(y[j + k]) : 32'd0);
            last  = (j + ppb[d] - 1 < n) ? j + ppb[d] - 1 : n - 1;
            e.cyc = 32'(cy[last] + 2);
            e.eol = (j + ppb[d] >= n);
            e.sof = sof_pend[d];
            sof_pend[d] = 1'b0;
            expq[d].push_back(e);
         end
      end
      pr.delete();
      pg.delete();
      pb.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_tests++;
      if ({va, da, sofa, eola, hsa, vsa, wa, ha} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: got v=%b d=%h sof=%b eol=%b hs=%b vs=%b w=%0d h=%0d expected all 0",
                  va, da, sofa, eola, hsa, vsa, wa, ha);
      end
      n_tests++;
      if ({vb, db, sofb, eolb, hsb, vsb, wb, hb} !== '0) begin
         n_fail++;
         $display("FAIL reset_b: got v=%b d=%h sof=%b eol=%b hs=%b vs=%b w=%0d h=%0d expected all 0",
                  vb, db, sofb, eolb, hsb, vsb, wb, hb);
      end
      rst_n = 1'b1;
      model_reset();
      step();
   endtask

   task automatic test_skip();
      for (int p = 0; p < 3; p++) begin
         add_rand_px(4);
         send_line(2);
         send_vsync();
      end
      add_rand_px(4);
      send_line(3);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (got[d].size() != expq[d].size()) begin
            n_fail++;
            $display("FAIL skip beat count dut%0d: got %0d expected %0d", d, got[d].size(), expq[d].size());
         end
         while (got[d].size() > 0 && expq[d].size() > 0) begin
            beat_t gv, ev;
            gv = got[d].pop_front();
            ev = expq[d].pop_front();
            n_tests++;
            if (gv !== ev) begin
               n_fail++;
               $display("FAIL skip beat dut%0d: got d=%h sof=%b eol=%b cyc=%0d expected d=%h sof=%b eol=%b cyc=%0d",
                        d, gv.data, gv.sof, gv.eol, gv.cyc, ev.data, ev.sof, ev.eol, ev.cyc);
            end
         end
         got[d].delete();
         expq[d].delete();
      end
   endtask

   task automatic test_pattern();
      send_vsync();
      add_px(255, 255, 255);
      add_px(0, 0, 0);
      add_px(128, 128, 128);
      add_px(64, 64, 64);
      send_line(2);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (got[d].size() != expq[d].size()) begin
            n_fail++;
            $display("FAIL pattern beat count dut%0d: got %0d expected %0d", d, got[d].size(), expq[d].size());
         end
         while (got[d].size() > 0 && expq[d].size() > 0) begin
            beat_t gv, ev;
            gv = got[d].pop_front();
            ev = expq[d].pop_front();
            n_tests++;
            if (gv !== ev) begin
               n_fail++;
               $display("FAIL pattern beat dut%0d: got d=%h sof=%b eol=%b cyc=%0d expected d=%h sof=%b eol=%b cyc=%0d",
                        d, gv.data, gv.sof, gv.eol, gv.cyc, ev.data, ev.sof, ev.eol, ev.cyc);
            end
         end
         got[d].delete();
         expq[d].delete();
      end
   endtask

   task automatic test_flush();
      send_vsync();
      for (int i = 0; i < 6; i++) add_px(16, 16, 16);
      send_line(2);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (got[d].size() != expq[d].size()) begin
            n_fail++;
            $display("FAIL flush beat count dut%0d: got %0d expected %0d", d, got[d].size(), expq[d].size());
         end
         while (got[d].size() > 0 && expq[d].size() > 0) begin
            beat_t gv, ev;
            gv = got[d].pop_front();
            ev = expq[d].pop_front();
            n_tests++;
            if (gv !== ev) begin
               n_fail++;
               $display("FAIL flush beat dut%0d: got d=%h sof=%b eol=%b cyc=%0d expected d=%h sof=%b eol=%b cyc=%0d",
                        d, gv.data, gv.sof, gv.eol, gv.cyc, ev.data, ev.sof, ev.eol, ev.cyc);
            end
         end
         got[d].delete();
         expq[d].delete();
      end
   endtask

   task automatic test_glitch();
      send_vsync();
      add_px(255, 0, 0);
      send_line(1);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (got[d].size() != expq[d].size()) begin
            n_fail++;
            $display("FAIL glitch beat count dut%0d: got %0d expected %0d", d, got[d].size(), expq[d].size());
         end
         while (got[d].size() > 0 && expq[d].size() > 0) begin
            beat_t gv, ev;
            gv = got[d].pop_front();
            ev = expq[d].pop_front();
            n_tests++;
            if (gv !== ev) begin
               n_fail++;
               $display("FAIL glitch beat dut%0d: got d=%h sof=%b eol=%b cyc=%0d expected d=%h sof=%b eol=%b cyc=%0d",
                        d, gv.data, gv.sof, gv.eol, gv.cyc, ev.data, ev.sof, ev.eol, ev.cyc);
            end
         end
         got[d].delete();
         expq[d].delete();
      end
   endtask

   task automatic test_back_to_back();
      for (int l = 0; l < 16; l++) begin
         if ($urandom_range(0, 3) == 0) send_vsync();
         add_rand_px(int'($urandom_range(1, 11)));
         send_line(int'($urandom_range(0, 2)));
      end
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (got[d].size() != expq[d].size()) begin
            n_fail++;
            $display("FAIL b2b beat count dut%0d: got %0d expected %0d", d, got[d].size(), expq[d].size());
         end
         while (got[d].size() > 0 && expq[d].size() > 0) begin
            beat_t gv, ev;
            gv = got[d].pop_front();
            ev = expq[d].pop_front();
            n_tests++;
            if (gv !== ev) begin
               n_fail++;
               $display("FAIL b2b beat dut%0d: got d=%h sof=%b eol=%b cyc=%0d expected d=%h sof=%b eol=%b cyc=%0d",
                        d, gv.data, gv.sof, gv.eol, gv.cyc, ev.data, ev.sof, ev.eol, ev.cyc);
            end
         end
         got[d].delete();
         expq[d].delete();
      end
   endtask

   task automatic test_measure();
      logic [15:0] exp_w, exp_h;
      exp_w = MEAS ? 16'd20 : 16'd0;
      exp_h = MEAS ? 16'd5 : 16'd0;
      send_vsync();
      for (int l = 0; l < 5; l++) begin
         add_rand_px(20);
         send_line(2);
         if (l == 0) begin
            n_tests++;
            if (wa !== exp_w || wb !== exp_w) begin
               n_fail++;
               $display("FAIL measure width: got a=%0d b=%0d expected %0d", wa, wb, exp_w);
            end
         end
      end
      send_vsync();
      n_tests++;
      if (ha !== exp_h || hb !== exp_h) begin
         n_fail++;
         $display("FAIL measure height: got a=%0d b=%0d expected %0d", ha, hb, exp_h);
      end
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (got[d].size() != expq[d].size()) begin
            n_fail++;
            $display("FAIL measure beat count dut%0d: got %0d expected %0d", d, got[d].size(), expq[d].size());
         end
         got[d].delete();
         expq[d].delete();
      end
   endtask

   task automatic test_reset_midline();
      send_vsync();
      de = 1'b1;
      r  = 8'hAA;
      g  = 8'h55;
      b  = 8'h11;
      step();
      r     = 8'h22;
      rst_n = 1'b0;
      step();
      n_tests++;
      if ({va, da, sofa, eola, hsa, vsa, wa, ha, vb, db, sofb, eolb, hsb, vsb, wb, hb} !== '0) begin
         n_fail++;
         $display("FAIL midline reset outputs: got va=%b da=%h vb=%b db=%h w=%0d/%0d h=%0d/%0d expected all 0",
                  va, da, vb, db, wa, wb, ha, hb);
      end
      de = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      step();
      step();
      add_rand_px(3);
      send_line(3);
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (got[d].size() != expq[d].size()) begin
            n_fail++;
            $display("FAIL midline beat count dut%0d: got %0d expected %0d", d, got[d].size(), expq[d].size());
         end
         while (got[d].size() > 0 && expq[d].size() > 0) begin
            beat_t gv, ev;
            gv = got[d].pop_front();
            ev = expq[d].pop_front();
            n_tests++;
            if (gv !== ev) begin
               n_fail++;
               $display("FAIL midline beat dut%0d: got d=%h sof=%b eol=%b cyc=%0d expected d=%h sof=%b eol=%b cyc=%0d",
                        d, gv.data, gv.sof, gv.eol, gv.cyc, ev.data, ev.sof, ev.eol, ev.cyc);
            end
         end
         got[d].delete();
         expq[d].delete();
      end
   endtask

   initial begin
      step();
      test_reset();
      test_skip();
      test_pattern();
      test_flush();
      test_glitch();
      test_back_to_back();
      test_measure();
      test_reset_midline();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
